// File: rtl/mem_access_unit_if.sv
// Bundle of the upstream accept, data-memory and writeback signals around mem_access_unit.
// The unit connects through the slave modport; the environment drives through master.
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [4:0]        dest_reg;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    logic              wb_valid;
    logic              wb_reg_write;
    logic [4:0]        wb_dest;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  in_valid, mem_read, mem_write, mem_to_reg, reg_write,
               alu_result, store_data, dest_reg, dmem_ack, dmem_rdata,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               wb_valid, wb_reg_write, wb_dest, wb_data
    );

    modport master (
        output in_valid, mem_read, mem_write, mem_to_reg, reg_write,
               alu_result, store_data, dest_reg, dmem_ack, dmem_rdata,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               wb_valid, wb_reg_write, wb_dest, wb_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage: takes one decoded instruction, performs at most one data-memory
// access over a req/ack handshake with timeout, then emits a single writeback beat.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus,
    input  logic             err_clr,
    output logic             err_align,
    output logic             err_timeout,
    output logic             err_ctl
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic               ok_p0;
    logic [DATA_W-1:0]  alu_p0, wdata_p0, rdata_p1;
    logic [4:0]         dest_p0;
    logic               we_p0, m2r_p0, rw_p0;

    logic accept, is_mem, bad_ctl, misalign, tmo, busy;

    assign accept   = bus.in_valid && (state == IDLE);
    assign is_mem   = bus.mem_read ^ bus.mem_write;
    assign bad_ctl  = bus.mem_read & bus.mem_write;
    assign misalign = is_mem && (bus.alu_result[1:0] != 2'b00);
    // Ack takes priority over a timeout landing in the same cycle.
    assign tmo      = (state == MEM) && !bus.dmem_ack && (cnt == CNT_W'(TIMEOUT - 1));
    assign busy     = (state != IDLE);

    always_comb begin
        next_state   = state;
        bus.in_ready = 1'b0;
        bus.dmem_req = 1'b0;
        bus.wb_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (accept)
                    next_state = (is_mem && !misalign) ? MEM : WB;
            end
            MEM: begin
                bus.dmem_req = 1'b1;
                if (bus.dmem_ack || tmo)
                    next_state = WB;
            end
            WB: begin
                bus.wb_valid = 1'b1;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ok_p0       <= 1'b0;
            err_align   <= 1'b0;
            err_timeout <= 1'b0;
            err_ctl     <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= (state == MEM) ? cnt + CNT_W'(1) : '0;
            if (accept)
                ok_p0 <= !bad_ctl && !misalign;
            else if (tmo)
                ok_p0 <= 1'b0;
            err_align   <= (accept && misalign) | (err_align & ~err_clr);
            err_timeout <= tmo | (err_timeout & ~err_clr);
            err_ctl     <= (accept && bad_ctl) | (err_ctl & ~err_clr);
        end
    end

    // Capture stage: operands latched on accept, load data latched on ack.
    always_ff @(posedge clk) begin
        if (accept) begin
            alu_p0   <= bus.alu_result;
            wdata_p0 <= bus.store_data;
            dest_p0  <= bus.dest_reg;
            we_p0    <= bus.mem_write;
            m2r_p0   <= bus.mem_to_reg;
            rw_p0    <= bus.reg_write;
        end
        if ((state == MEM) && bus.dmem_ack)
            rdata_p1 <= bus.dmem_rdata;
    end

    // Data registers are not reset, so outputs are gated by state to read 0 out of reset.
    assign bus.dmem_we      = busy & we_p0;
    assign bus.dmem_addr    = busy ? alu_p0[ADDR_W-1:0] : '0;
    assign bus.dmem_wdata   = busy ? wdata_p0 : '0;
    assign bus.wb_reg_write = bus.wb_valid & ok_p0 & rw_p0;
    assign bus.wb_dest      = bus.wb_valid ? dest_p0 : 5'd0;
    assign bus.wb_data      = bus.wb_valid ? (m2r_p0 ? rdata_p1 : alu_p0) : '0;
endmodule
